// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, WB write-through bypass and branch flush.
// Latency: one cycle from id_* to ex_*; pc_write/ifid_write are combinational from ex_* and id_*.
// Backpressure: on a load-use hazard, PC and IF/ID freeze for one cycle and a zero-control bubble enters EX.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   id_rs/rt/rd, id_data1/2       decode indices and register-file read data
//   id_imm, id_pc4, id_ctrl       immediate, PC+4, control bundle
//                                 (ctrl: 0 regWrite, 1 memRead, 2 memWrite, 3 memToReg, 4 aluSrc, 5 regDst, 7:6 aluOp)
//   flush                         branch/jump taken, squash the decoding instruction
//   wb_regWrite, wb_rd, wb_data   write-back port, bypassed into the captured operands
//   ex_*                          registered outputs to EX
//   pc_write, ifid_write          0 freezes PC and IF/ID
//   stall_count                   saturating count of stall cycles
module id_ex_stage #(
  parameter int DW  = 32,
  parameter int CW  = 8,
  parameter int SCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4:0]     id_rs,
  input  logic [4:0]     id_rt,
  input  logic [4:0]     id_rd,
  input  logic [DW-1:0]  id_data1,
  input  logic [DW-1:0]  id_data2,
  input  logic [DW-1:0]  id_imm,
  input  logic [DW-1:0]  id_pc4,
  input  logic [CW-1:0]  id_ctrl,
  input  logic           flush,
  input  logic           wb_regWrite,
  input  logic [4:0]     wb_rd,
  input  logic [DW-1:0]  wb_data,
  output logic [4:0]     ex_rs,
  output logic [4:0]     ex_rt,
  output logic [4:0]     ex_rd,
  output logic [DW-1:0]  ex_data1,
  output logic [DW-1:0]  ex_data2,
  output logic [DW-1:0]  ex_imm,
  output logic [DW-1:0]  ex_pc4,
  output logic [CW-1:0]  ex_ctrl,
  output logic           pc_write,
  output logic           ifid_write,
  output logic [SCW-1:0] stall_count
);

  logic          stall;
  logic [DW-1:0] byp1;
  logic [DW-1:0] byp2;

  // The register file writes on the same edge we capture, and its read ports
  // do not re-evaluate, so a same-cycle write-back must be forwarded here.
  // Register 0 is hardwired and never forwarded.
  always_comb begin
    byp1 = id_data1;
    byp2 = id_data2;
    if (wb_regWrite && (wb_rd != 5'd0) && (wb_rd == id_rs)) byp1 = wb_data;
    if (wb_regWrite && (wb_rd != 5'd0) && (wb_rd == id_rt)) byp2 = wb_data;
  end

  // A load in EX whose destination is a source of the decoding instruction
  // cannot be forwarded in time; hold decode for one cycle.
  assign stall = ex_ctrl[1] && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt));

  // A taken branch must redirect the PC even if a stall is also pending.
  assign pc_write   = ~stall | flush;
  assign ifid_write = ~stall | flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_data1    <= '0;
      ex_data2    <= '0;
      ex_imm      <= '0;
      ex_pc4      <= '0;
      ex_ctrl     <= '0;
      stall_count <= '0;
    end else begin
      // Indices and data always load; only the control bundle is zeroed
      // for a flush or a bubble, which makes the EX instruction inert.
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
      ex_data1 <= byp1;
      ex_data2 <= byp2;
      ex_imm   <= id_imm;
      ex_pc4   <= id_pc4;
      ex_ctrl  <= (flush || stall) ? '0 : id_ctrl;
      if (stall && !flush && (stall_count != {SCW{1'b1}}))
        stall_count <= stall_count + {{(SCW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_data1, id_data2, id_imm, id_pc4;
  logic [7:0]  id_ctrl;
  logic        flush;
  logic        wb_regWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_data1, ex_data2, ex_imm, ex_pc4;
  logic [7:0]  ex_ctrl;
  logic        pc_write, ifid_write;
  logic [15:0] stall_count;

  // Second instance with a 4-bit counter so saturation is reachable quickly.
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [31:0] s_data1, s_data2, s_imm, s_pc4;
  logic [7:0]  s_ctrl;
  logic        s_pcw, s_ifw;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .CW(8), .SCW(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_ctrl(id_ctrl), .flush(flush),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_ctrl(ex_ctrl), .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_count(stall_count)
  );

  id_ex_stage #(.DW(32), .CW(8), .SCW(4)) dut_s (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_ctrl(id_ctrl), .flush(flush),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .ex_data1(s_data1), .ex_data2(s_data2), .ex_imm(s_imm), .ex_pc4(s_pc4),
    .ex_ctrl(s_ctrl), .pc_write(s_pcw), .ifid_write(s_ifw),
    .stall_count(s_cnt)
  );

  // Reference model: what EX holds, and how many stall cycles have occurred.
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_d1, m_d2, m_imm, m_pc4;
  logic [7:0]  m_ctrl;
  int          m_cnt;

  function automatic bit m_hazard();
    // A load in EX writing a register the decoding instruction reads.
    return m_ctrl[1] == 1'b1 && m_rt != 0 && (m_rt == id_rs || m_rt == id_rt);
  endfunction

  function automatic logic [31:0] m_operand(input logic [4:0] idx, input logic [31:0] rf);
    if (wb_regWrite && wb_rd != 0 && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  function automatic int m_count16();
    return (m_cnt > 65535) ? 65535 : m_cnt;
  endfunction

  function automatic int m_count4();
    return (m_cnt > 15) ? 15 : m_cnt;
  endfunction

  task automatic model_reset();
    m_rs = 0; m_rt = 0; m_rd = 0;
    m_d1 = 0; m_d2 = 0; m_imm = 0; m_pc4 = 0;
    m_ctrl = 0; m_cnt = 0;
  endtask

  // Advance the model by one edge using the current inputs, then let the DUT
  // take the same edge and settle.
  task automatic tick();
    bit hz;
    hz = m_hazard();
    if (hz && !flush) m_cnt++;
    m_ctrl = (hz || flush) ? 8'h00 : id_ctrl;
    m_d1 = m_operand(id_rs, id_data1);
    m_d2 = m_operand(id_rt, id_data2);
    m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
    m_imm = id_imm; m_pc4 = id_pc4;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_rd = 0;
    id_data1 = 0; id_data2 = 0; id_imm = 0; id_pc4 = 0;
    id_ctrl = 0; flush = 0;
    wb_regWrite = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Build up five stall cycles and then load ex_ctrl = FF.
    idle_inputs();
    do_reset();
    checks++;
    if ({ex_rs, ex_rt, ex_rd, ex_ctrl, stall_count} !== '0) begin
      errors++;
      $display("FAIL reset_init got ctrl=%h cnt=%0d want 0", ex_ctrl, stall_count);
    end
    for (int i = 0; i < 5; i++) begin
      id_rs = 1; id_rt = 5; id_ctrl = 8'h02;
      tick();
      id_rs = 5; id_ctrl = 8'h01;
      tick();
    end
    id_rs = 9; id_rt = 10; id_rd = 11; id_data1 = 32'h1234; id_ctrl = 8'hFF;
    tick();
    checks++;
    if (ex_ctrl !== 8'hFF || stall_count !== 16'd5) begin
      errors++;
      $display("FAIL reset_setup got ctrl=%h cnt=%0d want ff 5", ex_ctrl, stall_count);
    end
    // Mid-cycle reset must clear everything before the next edge.
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({ex_rs, ex_rt, ex_rd, ex_data1, ex_data2, ex_imm, ex_pc4, ex_ctrl, stall_count} !== '0) begin
      errors++;
      $display("FAIL reset_async got rs=%0d d1=%h ctrl=%h cnt=%0d want all 0",
               ex_rs, ex_data1, ex_ctrl, stall_count);
    end
    checks++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
      errors++;
      $display("FAIL reset_pcwrite got %b%b want 11", pc_write, ifid_write);
    end
    #1;
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_normal_capture();
    idle_inputs();
    id_rs = 3; id_rt = 4; id_rd = 6;
    id_data1 = 32'h11; id_data2 = 32'h22; id_imm = 32'hFFFF_FFF0;
    id_pc4 = 32'h0000_0104; id_ctrl = 8'h31;
    #1;
    checks++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
      errors++;
      $display("FAIL normal_pcwrite got %b%b want 11", pc_write, ifid_write);
    end
    tick();
    checks++;
    if ({ex_rs, ex_rt, ex_rd, ex_data1, ex_data2, ex_imm, ex_pc4, ex_ctrl} !==
        {5'd3, 5'd4, 5'd6, 32'h11, 32'h22, 32'hFFFF_FFF0, 32'h104, 8'h31}) begin
      errors++;
      $display("FAIL normal_capture got rs=%0d rt=%0d rd=%0d d1=%h d2=%h imm=%h pc4=%h ctrl=%h",
               ex_rs, ex_rt, ex_rd, ex_data1, ex_data2, ex_imm, ex_pc4, ex_ctrl);
    end
  endtask

  task automatic test_load_use();
    int c0;
    idle_inputs();
    id_rs = 1; id_rt = 5; id_ctrl = 8'h0B;
    tick();
    c0 = stall_count;
    id_rs = 5; id_rt = 6; id_rd = 7; id_ctrl = 8'h01;
    #1;
    checks++;
    if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin
      errors++;
      $display("FAIL loaduse_stall got %b%b want 00", pc_write, ifid_write);
    end
    tick();
    checks++;
    if (ex_ctrl !== 8'h00 || stall_count !== 16'(c0 + 1)) begin
      errors++;
      $display("FAIL loaduse_bubble got ctrl=%h cnt=%0d want 00 %0d", ex_ctrl, stall_count, c0 + 1);
    end
    checks++;
    if (pc_write !== 1'b1) begin
      errors++;
      $display("FAIL loaduse_release got %b want 1", pc_write);
    end
    tick();
    checks++;
    if (ex_ctrl !== 8'h01 || ex_rs !== 5'd5 || stall_count !== 16'(c0 + 1)) begin
      errors++;
      $display("FAIL loaduse_capture got ctrl=%h rs=%0d cnt=%0d want 01 5 %0d",
               ex_ctrl, ex_rs, stall_count, c0 + 1);
    end
    // Load into register 0 never stalls.
    id_rs = 1; id_rt = 0; id_ctrl = 8'h0B;
    tick();
    id_rs = 0; id_rt = 0; id_ctrl = 8'h01;
    #1;
    checks++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
      errors++;
      $display("FAIL loaduse_r0 got %b%b want 11", pc_write, ifid_write);
    end
    tick();
    checks++;
    if (ex_ctrl !== 8'h01 || stall_count !== 16'(c0 + 1)) begin
      errors++;
      $display("FAIL loaduse_r0_capture got ctrl=%h cnt=%0d want 01 %0d", ex_ctrl, stall_count, c0 + 1);
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    wb_regWrite = 1; wb_rd = 7; wb_data = 32'hDEAD_BEEF;
    id_rs = 7; id_rt = 7; id_ctrl = 8'h21;
    tick();
    checks++;
    if (ex_data1 !== 32'hDEAD_BEEF || ex_data2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_hit got %h %h want deadbeef", ex_data1, ex_data2);
    end
    wb_rd = 0; id_rs = 0; id_rt = 2; id_data1 = 0; id_data2 = 32'h55;
    tick();
    checks++;
    if (ex_data1 !== 32'h0 || ex_data2 !== 32'h55) begin
      errors++;
      $display("FAIL bypass_r0 got %h %h want 0 55", ex_data1, ex_data2);
    end
    wb_regWrite = 0; wb_rd = 2;
    tick();
    checks++;
    if (ex_data2 !== 32'h55) begin
      errors++;
      $display("FAIL bypass_nowrite got %h want 55", ex_data2);
    end
  endtask

  task automatic test_flush_stall();
    int c0;
    idle_inputs();
    id_rs = 1; id_rt = 5; id_ctrl = 8'h0B;
    tick();
    c0 = stall_count;
    id_rs = 5; id_rt = 9; id_rd = 12; id_data1 = 32'hA5; id_ctrl = 8'h01; flush = 1;
    #1;
    checks++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
      errors++;
      $display("FAIL flush_pcwrite got %b%b want 11", pc_write, ifid_write);
    end
    tick();
    checks++;
    if (ex_ctrl !== 8'h00 || stall_count !== 16'(c0) || ex_rs !== 5'd5 ||
        ex_rd !== 5'd12 || ex_data1 !== 32'hA5) begin
      errors++;
      $display("FAIL flush_capture got ctrl=%h cnt=%0d rs=%0d rd=%0d d1=%h want 00 %0d 5 12 a5",
               ex_ctrl, stall_count, ex_rs, ex_rd, ex_data1, c0);
    end
    flush = 0;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 31));
      id_data1 = $urandom; id_data2 = $urandom;
      id_imm = $urandom; id_pc4 = $urandom;
      id_ctrl = 8'($urandom);
      flush = ($urandom_range(0, 7) == 0);
      wb_regWrite = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3));
      wb_data = $urandom;
      #1;
      checks++;
      if (pc_write !== (!m_hazard() || flush) || ifid_write !== pc_write) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_pcwrite cyc %0d got %b%b want %b", i, pc_write, ifid_write,
                               (!m_hazard() || flush));
      end
      tick();
      checks++;
      if ({ex_rs, ex_rt, ex_rd, ex_data1, ex_data2, ex_imm, ex_pc4, ex_ctrl} !==
          {m_rs, m_rt, m_rd, m_d1, m_d2, m_imm, m_pc4, m_ctrl} ||
          stall_count !== 16'(m_count16()) || s_cnt !== 4'(m_count4())) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_ex cyc %0d got ctrl=%h d1=%h d2=%h cnt=%0d/%0d want ctrl=%h d1=%h d2=%h cnt=%0d/%0d",
                               i, ex_ctrl, ex_data1, ex_data2, stall_count, s_cnt,
                               m_ctrl, m_d1, m_d2, m_count16(), m_count4());
      end
    end
  endtask

  task automatic test_saturation();
    idle_inputs();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      id_rs = 1; id_rt = 5; id_ctrl = 8'h02;
      tick();
      id_rs = 5; id_ctrl = 8'h01;
      tick();
      checks++;
      if (s_cnt !== 4'((i > 15) ? 15 : i) || stall_count !== 16'(i)) begin
        errors++;
        $display("FAIL saturate step %0d got %0d/%0d want %0d/%0d", i, s_cnt, stall_count,
                 (i > 15) ? 15 : i, i);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #2;
    test_reset();
    test_normal_capture();
    test_load_use();
    test_bypass();
    test_flush_stall();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
